// File: rtl/pipeline_mem_stage_if.sv
// Data-memory request/ready bus between the memory stage and the data memory.
interface pipeline_mem_stage_if;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [3:0]  dmem_be;
   logic        dmem_ready;
   logic [31:0] dmem_rdata;

   modport master (
      output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
      input  dmem_ready, dmem_rdata
   );

   modport slave (
      input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
      output dmem_ready, dmem_rdata
   );
endinterface

// File: rtl/pipeline_mem_stage.sv
// Memory-access stage and MEM/WB pipeline register.
// Issues loads/stores over a req/ready bus, stalls upstream while an access
// is outstanding, steers byte/halfword lanes and extends loaded data.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | accepting from EX/MEM; non-memory ops pass straight to MEM/WB
// ACCESS | memory request outstanding, upstream held until ready/timeout
module pipeline_mem_stage #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ex_valid,
   input  logic        flush,
   input  logic [4:0]  rd_write_address_in,
   input  logic        rd_write_enable_in,
   input  logic        rd_select_in,
   input  logic [31:0] alu_result_in,
   input  logic [31:0] store_data_in,
   input  logic        mem_read_in,
   input  logic        mem_write_in,
   input  logic [1:0]  mem_size_in,
   input  logic        mem_unsigned_in,
   pipeline_mem_stage_if.master dmem,
   output logic        stall_out,
   output logic        wb_valid,
   output logic [4:0]  rd_write_address_out,
   output logic        rd_write_enable_out,
   output logic        rd_select_out,
   output logic [31:0] alu_result_out,
   output logic [31:0] dmem_data_out,
   output logic        misalign_exc,
   output logic        bus_err
);

   typedef enum logic {IDLE, ACCESS} state_t;

   // Counter only has to reach TIMEOUT_CYCLES-1 before it is cleared.
   localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_TERM =
      CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // captured access
   logic [31:0] addr_q, addr_d;
   logic [1:0]  size_q, size_d;
   logic        uns_q, uns_d;
   logic        store_q, store_d;
   logic [31:0] sdata_q, sdata_d;
   logic [4:0]  cap_rd_addr_q, cap_rd_addr_d;
   logic        cap_rd_we_q, cap_rd_we_d;
   logic        cap_rd_sel_q, cap_rd_sel_d;

   // MEM/WB register
   logic        wb_valid_q, wb_valid_d;
   logic [4:0]  rd_addr_q, rd_addr_d;
   logic        rd_we_q, rd_we_d;
   logic        rd_sel_q, rd_sel_d;
   logic [31:0] alu_q, alu_d;
   logic [31:0] data_q, data_d;
   logic        misalign_q, misalign_d;
   logic        bus_err_q, bus_err_d;

   logic        take, is_mem, bad_align, timeout_hit, stall_c;
   logic [1:0]  off;
   logic [15:0] lane;
   logic [31:0] load_ext, wdata_c;
   logic [3:0]  be_c;

   // Decode of the instruction presented by EX/MEM.
   always_comb begin
      take   = ex_valid & ~flush;
      is_mem = mem_read_in | mem_write_in;
      case (mem_size_in)
         2'b00:   bad_align = 1'b0;
         2'b01:   bad_align = alu_result_in[0];
         2'b10:   bad_align = |alu_result_in[1:0];
         default: bad_align = 1'b1;
      endcase
   end

   // Store lane steering and load extraction, all from the captured access.
   always_comb begin
      off  = addr_q[1:0];
      lane = 16'(dmem.dmem_rdata >> {off, 3'b000});
      case (size_q)
         2'b00: begin
            be_c     = 4'b0001 << off;
            wdata_c  = {4{sdata_q[7:0]}};
            load_ext = uns_q ? {24'd0, lane[7:0]} : {{24{lane[7]}}, lane[7:0]};
         end
         2'b01: begin
            be_c     = 4'b0011 << off;
            wdata_c  = {2{sdata_q[15:0]}};
            load_ext = uns_q ? {16'd0, lane} : {{16{lane[15]}}, lane};
         end
         default: begin
            be_c     = 4'b1111;
            wdata_c  = sdata_q;
            load_ext = dmem.dmem_rdata;
         end
      endcase
      if (!store_q) be_c = 4'b1111;
   end

   // Next-state, capture and MEM/WB load decisions.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      addr_d        = addr_q;
      size_d        = size_q;
      uns_d         = uns_q;
      store_d       = store_q;
      sdata_d       = sdata_q;
      cap_rd_addr_d = cap_rd_addr_q;
      cap_rd_we_d   = cap_rd_we_q;
      cap_rd_sel_d  = cap_rd_sel_q;
      wb_valid_d    = 1'b0;
      rd_we_d       = 1'b0;
      misalign_d    = 1'b0;
      bus_err_d     = 1'b0;
      rd_addr_d     = rd_addr_q;
      rd_sel_d      = rd_sel_q;
      alu_d         = alu_q;
      data_d        = data_q;
      stall_c       = 1'b0;
      timeout_hit   = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_TERM);

      case (state_q)
         IDLE: begin
            if (take) begin
               if (!is_mem) begin
                  wb_valid_d = 1'b1;
                  rd_addr_d  = rd_write_address_in;
                  rd_we_d    = rd_write_enable_in;
                  rd_sel_d   = rd_select_in;
                  alu_d      = alu_result_in;
                  data_d     = 32'd0;
               end else if (bad_align) begin
                  wb_valid_d = 1'b1;
                  rd_addr_d  = rd_write_address_in;
                  rd_sel_d   = rd_select_in;
                  alu_d      = alu_result_in;
                  data_d     = 32'd0;
                  misalign_d = 1'b1;
               end else begin
                  stall_c       = 1'b1;
                  addr_d        = alu_result_in;
                  size_d        = mem_size_in;
                  uns_d         = mem_unsigned_in;
                  store_d       = mem_write_in;
                  sdata_d       = store_data_in;
                  cap_rd_addr_d = rd_write_address_in;
                  cap_rd_we_d   = rd_write_enable_in;
                  cap_rd_sel_d  = rd_select_in;
                  cnt_d         = '0;
                  state_d       = ACCESS;
               end
            end
         end
         ACCESS: begin
            // flush is deliberately ignored here: the bus access must finish
            stall_c = 1'b1;
            if (dmem.dmem_ready || timeout_hit) begin
               stall_c    = 1'b0;
               state_d    = IDLE;
               cnt_d      = '0;
               wb_valid_d = 1'b1;
               rd_addr_d  = cap_rd_addr_q;
               rd_sel_d   = cap_rd_sel_q;
               alu_d      = addr_q;
               if (dmem.dmem_ready) begin
                  rd_we_d = cap_rd_we_q;
                  data_d  = store_q ? 32'd0 : load_ext;
               end else begin
                  data_d    = 32'd0;
                  bus_err_d = 1'b1;
               end
            end else if (TIMEOUT_CYCLES != 0) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, captured access and MEM/WB registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         addr_q        <= '0;
         size_q        <= '0;
         uns_q         <= 1'b0;
         store_q       <= 1'b0;
         sdata_q       <= '0;
         cap_rd_addr_q <= '0;
         cap_rd_we_q   <= 1'b0;
         cap_rd_sel_q  <= 1'b0;
         wb_valid_q    <= 1'b0;
         rd_addr_q     <= '0;
         rd_we_q       <= 1'b0;
         rd_sel_q      <= 1'b0;
         alu_q         <= '0;
         data_q        <= '0;
         misalign_q    <= 1'b0;
         bus_err_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         addr_q        <= addr_d;
         size_q        <= size_d;
         uns_q         <= uns_d;
         store_q       <= store_d;
         sdata_q       <= sdata_d;
         cap_rd_addr_q <= cap_rd_addr_d;
         cap_rd_we_q   <= cap_rd_we_d;
         cap_rd_sel_q  <= cap_rd_sel_d;
         wb_valid_q    <= wb_valid_d;
         rd_addr_q     <= rd_addr_d;
         rd_we_q       <= rd_we_d;
         rd_sel_q      <= rd_sel_d;
         alu_q         <= alu_d;
         data_q        <= data_d;
         misalign_q    <= misalign_d;
         bus_err_q     <= bus_err_d;
      end
   end

   // Bus and WB outputs; stall is masked during reset since IDLE stall is
   // combinational from EX/MEM inputs.
   always_comb begin
      dmem.dmem_req        = (state_q == ACCESS);
      dmem.dmem_we         = (state_q == ACCESS) & store_q;
      dmem.dmem_addr       = {addr_q[31:2], 2'b00};
      dmem.dmem_wdata      = wdata_c;
      dmem.dmem_be         = be_c;
      stall_out            = stall_c & rst_n;
      wb_valid             = wb_valid_q;
      rd_write_address_out = rd_addr_q;
      rd_write_enable_out  = rd_we_q;
      rd_select_out        = rd_sel_q;
      alu_result_out       = alu_q;
      dmem_data_out        = data_q;
      misalign_exc         = misalign_q;
      bus_err              = bus_err_q;
   end

endmodule

// File: tb/tb_pipeline_mem_stage.sv
// Self-checking bench for pipeline_mem_stage: directed cases plus randomized
// instruction stream checked against a transaction-level reference model.
module tb_pipeline_mem_stage;
   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ex_valid, flush;
   logic [4:0]  rd_write_address_in;
   logic        rd_write_enable_in, rd_select_in;
   logic [31:0] alu_result_in, store_data_in;
   logic        mem_read_in, mem_write_in;
   logic [1:0]  mem_size_in;
   logic        mem_unsigned_in;
   logic        stall_out, wb_valid;
   logic [4:0]  rd_write_address_out;
   logic        rd_write_enable_out, rd_select_out;
   logic [31:0] alu_result_out, dmem_data_out;
   logic        misalign_exc, bus_err;

   int n_checks = 0;
   int n_errors = 0;

   pipeline_mem_stage_if dbus ();

   pipeline_mem_stage #(.TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .flush(flush),
      .rd_write_address_in(rd_write_address_in),
      .rd_write_enable_in(rd_write_enable_in), .rd_select_in(rd_select_in),
      .alu_result_in(alu_result_in), .store_data_in(store_data_in),
      .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
      .mem_size_in(mem_size_in), .mem_unsigned_in(mem_unsigned_in),
      .dmem(dbus.master), .stall_out(stall_out), .wb_valid(wb_valid),
      .rd_write_address_out(rd_write_address_out),
      .rd_write_enable_out(rd_write_enable_out), .rd_select_out(rd_select_out),
      .alu_result_out(alu_result_out), .dmem_data_out(dmem_data_out),
      .misalign_exc(misalign_exc), .bus_err(bus_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        v, fl;
      logic [4:0]  rd;
      logic        we, sel;
      logic [31:0] alu, sd;
      logic        ld, st;
      logic [1:0]  sz;
      logic        uns;
   } instr_t;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference: loaded value from the read word by plain arithmetic.
   function automatic logic [31:0] ref_load(input logic [31:0] rdata, input logic [31:0] addr,
                                            input logic [1:0] sz, input logic uns);
      int unsigned lane, v;
      lane = rdata >> (8 * (addr % 4));
      if (sz == 0) begin
         v = lane % 256;
         return (uns || v < 128) ? v : v + 32'hFFFFFF00;
      end else if (sz == 1) begin
         v = lane % 65536;
         return (uns || v < 32768) ? v : v + 32'hFFFF0000;
      end
      return rdata;
   endfunction

   function automatic logic [3:0] ref_be(input instr_t i);
      int unsigned w;
      if (!i.st) return 4'hF;
      w = (i.sz == 0) ? 1 : (i.sz == 1) ? 3 : 15;
      return 4'((w << (i.alu % 4)) % 16);
   endfunction

   function automatic logic [31:0] ref_wdata(input instr_t i);
      if (i.sz == 0) return (i.sd % 256) * 32'h01010101;
      if (i.sz == 1) return (i.sd % 65536) * 32'h00010001;
      return i.sd;
   endfunction

   task automatic drive(input instr_t i);
      ex_valid            = i.v;
      flush               = i.fl;
      rd_write_address_in = i.rd;
      rd_write_enable_in  = i.we;
      rd_select_in        = i.sel;
      alu_result_in       = i.alu;
      store_data_in       = i.sd;
      mem_read_in         = i.ld;
      mem_write_in        = i.st;
      mem_size_in         = i.sz;
      mem_unsigned_in     = i.uns;
   endtask

   // One instruction end to end; lat = ACCESS cycles without ready before ready.
   task automatic run(input instr_t i, input int lat, input logic [31:0] rdata,
                      input logic fl_acc);
      bit kill, mem, bad, go, rdy, tmo, done;
      int req_cycles;
      kill = !i.v || i.fl;
      mem  = i.ld || i.st;
      bad  = mem && (i.sz == 3 || (i.alu % (32'd1 << i.sz)) != 0);
      go   = !kill && mem && !bad;
      rdy  = 0;
      tmo  = 0;
      req_cycles = 0;
      @(negedge clk);
      drive(i);
      dbus.dmem_ready = 1'b0;
      #1;
      chk("stall_accept", 32'(stall_out), 32'(go));
      chk("req_idle", 32'(dbus.dmem_req), 0);
      @(posedge clk);
      if (go) begin
         done = 0;
         for (int cyc = 1; cyc <= TO && !done; cyc++) begin
            @(negedge clk);
            if (fl_acc) flush = 1'b1;
            rdy = (cyc == lat + 1);
            dbus.dmem_ready = rdy;
            dbus.dmem_rdata = rdy ? rdata : $urandom;
            #1;
            req_cycles += int'(dbus.dmem_req);
            if (cyc == 1) begin
               chk("addr", dbus.dmem_addr, i.alu & 32'hFFFFFFFC);
               chk("we", 32'(dbus.dmem_we), 32'(i.st));
               chk("be", 32'(dbus.dmem_be), 32'(ref_be(i)));
               if (i.st) chk("wdata", dbus.dmem_wdata, ref_wdata(i));
            end
            tmo = !rdy && cyc == TO;
            chk("stall_access", 32'(stall_out), 32'(!(rdy || tmo)));
            done = rdy || tmo;
            @(posedge clk);
         end
         chk("req_cycles", req_cycles, (lat + 1 < TO) ? lat + 1 : TO);
      end
      #1;
      dbus.dmem_ready = 1'b0;
      ex_valid = 1'b0;
      flush = 1'b0;
      chk("req_after", 32'(dbus.dmem_req), 0);
      chk("wb_valid", 32'(wb_valid), 32'(!kill));
      chk("misalign", 32'(misalign_exc), 32'(!kill && bad));
      chk("bus_err", 32'(bus_err), 32'(go && tmo));
      chk("rd_we", 32'(rd_write_enable_out), 32'(!kill && !bad && !tmo && i.we));
      if (!kill) begin
         chk("rd_addr", 32'(rd_write_address_out), 32'(i.rd));
         chk("rd_sel", 32'(rd_select_out), 32'(i.sel));
         chk("alu", alu_result_out, i.alu);
         if (!mem) chk("data_alu", dmem_data_out, 0);
         if (go && rdy) chk("data_mem", dmem_data_out, i.ld ? ref_load(rdata, i.alu, i.sz, i.uns) : 0);
      end
   endtask

   function automatic instr_t mk(input logic ld, input logic st, input logic [1:0] sz,
                                 input logic uns, input logic [31:0] alu, input logic [31:0] sd);
      instr_t i;
      i.v = 1; i.fl = 0; i.rd = 5'd7; i.we = ld; i.sel = !(ld || st);
      i.alu = alu; i.sd = sd; i.ld = ld; i.st = st; i.sz = sz; i.uns = uns;
      return i;
   endfunction

   initial begin
      instr_t i;
      int kind;
      rst_n = 1'b0;
      drive(mk(0, 0, 2'b10, 0, 0, 0));
      ex_valid = 1'b0;
      dbus.dmem_ready = 1'b0;
      dbus.dmem_rdata = '0;
      #1;
      chk("rst_wb_valid", 32'(wb_valid), 0);
      chk("rst_req", 32'(dbus.dmem_req), 0);
      chk("rst_stall", 32'(stall_out), 0);
      chk("rst_alu", alu_result_out, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // ALU op
      i = mk(0, 0, 2'b10, 0, 32'h1234, 0);
      i.rd = 5'd5; i.we = 1;
      run(i, 0, 0, 0);
      // lb / lbu at 0x103
      run(mk(1, 0, 2'b00, 0, 32'h103, 0), 1, 32'h80FFFFFF, 0);
      chk("lb_const", dmem_data_out, 32'hFFFFFF80);
      run(mk(1, 0, 2'b00, 1, 32'h103, 0), 1, 32'h80FFFFFF, 0);
      chk("lbu_const", dmem_data_out, 32'h00000080);
      // sh at 0x202
      run(mk(0, 1, 2'b01, 0, 32'h202, 32'hABCD1234), 0, 0, 0);
      // misaligned lw
      run(mk(1, 0, 2'b10, 0, 32'h301, 0), 0, 0, 0);
      // timeout
      run(mk(1, 0, 2'b10, 0, 32'h400, 0), 100, 0, 0);
      // ready on the timeout cycle wins
      run(mk(1, 0, 2'b10, 0, 32'h404, 0), TO - 1, 32'hCAFEF00D, 1);
      // flushed load becomes a bubble
      i = mk(1, 0, 2'b10, 0, 32'h500, 0);
      i.fl = 1;
      run(i, 0, 0, 0);

      // reset in the second ACCESS cycle
      @(negedge clk);
      drive(mk(1, 0, 2'b10, 0, 32'h600, 0));
      @(posedge clk);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_req", 32'(dbus.dmem_req), 0);
      chk("rst_mid_stall", 32'(stall_out), 0);
      chk("rst_mid_wb", 32'(wb_valid), 0);
      @(negedge clk);
      ex_valid = 1'b0;
      rst_n = 1'b1;
      run(mk(1, 0, 2'b10, 0, 32'h604, 0), 2, 32'h13572468, 0);

      // randomized stream
      for (int n = 0; n < 300; n++) begin
         kind = $urandom_range(0, 2);
         i.v   = ($urandom_range(0, 9) != 0);
         i.fl  = ($urandom_range(0, 9) == 0);
         i.rd  = 5'($urandom);
         i.we  = 1'($urandom);
         i.sel = 1'($urandom);
         i.alu = $urandom;
         i.sd  = $urandom;
         i.ld  = (kind == 1);
         i.st  = (kind == 2);
         i.sz  = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
         i.uns = 1'($urandom);
         if ($urandom_range(0, 1) == 1) i.alu[1:0] = 2'b00;
         run(i, $urandom_range(0, 5), $urandom, ($urandom_range(0, 3) == 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
